// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sync pattern, zero-stuffed MSB-first payload, idle gap.
// Feeds the single-bit input of the downstream Moore sequence detector.
module serial_frame_tx #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 4,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011,
  parameter int                GAP_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam int DCW  = $clog2(DATA_W + 1);
  localparam int PMAX = (SYNC_W > GAP_CYCLES) ? SYNC_W : GAP_CYCLES;
  localparam int PCW  = (PMAX < 1) ? 1 : $clog2(PMAX + 1);

  localparam logic [DCW-1:0] DATA_N  = DCW'(DATA_W);
  localparam logic [DCW-1:0] D_ONE   = DCW'(1);
  localparam logic [PCW-1:0] SYNC_N  = PCW'(SYNC_W);
  localparam logic [PCW-1:0] GAP_N   = PCW'(GAP_CYCLES);
  localparam logic [PCW-1:0] P_ONE   = PCW'(1);
  localparam bit             HAS_GAP = (GAP_CYCLES > 0);

  logic [1:0]        state, nxt_state;
  logic [PCW-1:0]    pcnt, nxt_pcnt;
  logic [DCW-1:0]    dcnt, nxt_dcnt;
  logic [DATA_W-1:0] shreg, nxt_shreg;
  logic [SYNC_W-1:0] sync_sr, nxt_sync;
  logic [2:0]        hist;
  logic              emit, emit_bit, emit_last, data_slot;

  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // Outputs are registered, so each cycle decides the bit for the next one;
  // frame_done is therefore predicted from the post-emission history.
  always_comb begin
    nxt_state = state;
    nxt_pcnt  = pcnt;
    nxt_dcnt  = dcnt;
    nxt_shreg = shreg;
    nxt_sync  = sync_sr;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    emit_last = 1'b0;
    data_slot = 1'b0;

    case (state)
      IDLE: begin
        if (data_valid) begin
          nxt_state = SYNC;
          nxt_shreg = data_in;
          nxt_sync  = SYNC_PATTERN << 1;
          nxt_pcnt  = P_ONE;
          nxt_dcnt  = '0;
          emit      = 1'b1;
          emit_bit  = SYNC_PATTERN[SYNC_W-1];
        end
      end
      SYNC: begin
        if (pcnt != SYNC_N) begin
          emit     = 1'b1;
          emit_bit = sync_sr[SYNC_W-1];
          nxt_sync = sync_sr << 1;
          nxt_pcnt = pcnt + P_ONE;
        end else begin
          data_slot = 1'b1;
        end
      end
      DATA: data_slot = 1'b1;
      GAP: begin
        if (pcnt != GAP_N) begin
          emit      = 1'b1;
          nxt_pcnt  = pcnt + P_ONE;
          emit_last = ((pcnt + P_ONE) == GAP_N);
        end else begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase

    if (data_slot) begin
      if (hist == 3'b101) begin
        // Stuffed zero; the pending data bit stays at the shift register MSB.
        nxt_state = DATA;
        emit      = 1'b1;
        emit_last = !HAS_GAP && (dcnt == DATA_N);
      end else if (dcnt != DATA_N) begin
        nxt_state = DATA;
        emit      = 1'b1;
        emit_bit  = shreg[DATA_W-1];
        nxt_shreg = shreg << 1;
        nxt_dcnt  = dcnt + D_ONE;
        emit_last = !HAS_GAP && (nxt_dcnt == DATA_N) &&
                    ({hist[1:0], emit_bit} != 3'b101);
      end else if (HAS_GAP) begin
        nxt_state = GAP;
        nxt_pcnt  = P_ONE;
        emit      = 1'b1;
        emit_last = (GAP_N == P_ONE);
      end else begin
        nxt_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      dcnt       <= '0;
      shreg      <= '0;
      sync_sr    <= '0;
      hist       <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      pcnt       <= nxt_pcnt;
      dcnt       <= nxt_dcnt;
      shreg      <= nxt_shreg;
      sync_sr    <= nxt_sync;
      bit_out    <= emit & emit_bit;
      bit_valid  <= emit;
      frame_done <= emit_last;
      if (nxt_state == IDLE)
        hist <= '0;
      else if (emit)
        hist <= {hist[1:0], emit_bit};
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed frames, mid-frame reset and random words,
// compared with a bit-list frame builder and a stuffing-aware payload decoder.
module tb_serial_frame_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_bit, a_bv, a_busy, a_done;
  logic       b_ready, b_bit, b_bv, b_busy, b_done;
  bit         stream[$];

  serial_frame_tx u_dut (
    .clk(clk), .reset(reset), .data_in(a_data), .data_valid(a_valid),
    .data_ready(a_ready), .bit_out(a_bit), .bit_valid(a_bv),
    .busy(a_busy), .frame_done(a_done)
  );

  serial_frame_tx #(.GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .data_in(b_data), .data_valid(b_valid),
    .data_ready(b_ready), .bit_out(b_bit), .bit_valid(b_bv),
    .busy(b_busy), .frame_done(b_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ends101(input bit q[$]);
    return q[$-2] == 1'b1 && q[$-1] == 1'b0 && q[$] == 1'b1;
  endfunction

  // Frame as a bit list: sync, payload with a zero inserted after every 101, gap zeros.
  function automatic void model(input logic [7:0] w, input int gap,
                                output logic [63:0] v, output int n);
    bit q[$];
    q = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 7; i >= 0; i--) begin
      if (ends101(q)) q.push_back(1'b0);
      q.push_back(w[i]);
    end
    if (ends101(q)) q.push_back(1'b0);
    for (int i = 0; i < gap; i++) q.push_back(1'b0);
    v = '0;
    foreach (q[i]) v = {v[62:0], q[i]};
    n = q.size();
  endfunction

  function automatic int count1011(input logic [63:0] v, input int n);
    int c = 0;
    for (int i = 0; i + 4 <= n; i++)
      if (v[n-1-i -: 4] == 4'b1011) c++;
    return c;
  endfunction

  function automatic logic [7:0] decode(input logic [63:0] v, input int n);
    logic [7:0] d = '0;
    for (int i = 4; i < n; i++) begin
      if (!(v[n-1-(i-3)] == 1'b1 && v[n-1-(i-2)] == 1'b0 && v[n-1-(i-1)] == 1'b1))
        d = {d[6:0], v[n-1-i]};
    end
    return d;
  endfunction

  // Entered at a negedge with the selected DUT idle; returns at the negedge holding frame_done.
  task automatic run_frame(input bit sel, input logic [7:0] w, input bit keep_valid,
                           output logic [63:0] v, output int n, output bit flags_ok);
    logic bo, bv, bz, rd, dn;
    if (sel) begin b_data = w; b_valid = 1'b1; end
    else     begin a_data = w; a_valid = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if (sel) begin b_data = 8'($urandom); b_valid = keep_valid; end
    else     begin a_data = 8'($urandom); a_valid = keep_valid; end
    v = '0; n = 0; flags_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bo = sel ? b_bit : a_bit;   bv = sel ? b_bv : a_bv;
      bz = sel ? b_busy : a_busy; rd = sel ? b_ready : a_ready;
      dn = sel ? b_done : a_done;
      v = {v[62:0], bo};
      n++;
      if (!(bv === 1'b1 && bz === 1'b1 && rd === 1'b0)) flags_ok = 1'b0;
      if (sel) stream.push_back(bo);
      if (dn === 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic idle_check(input bit sel, input string tag);
    @(negedge clk);
    if (sel) begin
      stream.push_back(b_bit);
      chk(tag, {b_ready, b_bv, b_busy, b_bit, b_done}, 5'b10000);
    end else begin
      chk(tag, {a_ready, a_bv, a_busy, a_bit, a_done}, 5'b10000);
    end
  endtask

  task automatic frame_test(input bit sel, input logic [7:0] w, input bit keep_valid,
                            input string tag, output logic [63:0] v);
    logic [63:0] ev;
    int n, en;
    bit ok;
    run_frame(sel, w, keep_valid, v, n, ok);
    model(w, sel ? 0 : 2, ev, en);
    chk({tag, "_len"}, n, en);
    chk({tag, "_bits"}, v, ev);
    chk({tag, "_flags"}, ok, 1);
    chk({tag, "_sync_once"}, count1011(v, n), 1);
    if (sel) chk({tag, "_payload"}, decode(v, n), w);
  endtask

  initial begin
    logic [63:0] v;
    logic [7:0]  w;
    int          pulses;

    reset = 1'b1;
    a_valid = 1'b1; a_data = 8'hA5;
    b_valid = 1'b1; b_data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("reset_a", {a_ready, a_bv, a_busy, a_bit, a_done}, 5'b10000);
      chk("reset_b", {b_ready, b_bv, b_busy, b_bit, b_done}, 5'b10000);
    end
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    idle_check(0, "post_reset_a");
    idle_check(1, "post_reset_b");
    stream.delete();

    frame_test(0, 8'hA5, 1'b0, "a5", v);
    chk("a5_const", v, 64'b1011_1010001010_00);
    idle_check(0, "a5_idle");

    frame_test(0, 8'h00, 1'b0, "zero", v);
    chk("zero_const", v, 64'b1011_00000000_00);
    idle_check(0, "zero_idle");
    frame_test(0, 8'hFF, 1'b0, "ones", v);
    chk("ones_const", v, 64'b1011_11111111_00);
    idle_check(0, "ones_idle");

    // Back-to-back with data_valid held high throughout.
    frame_test(0, 8'h5A, 1'b1, "b2b_1", v);
    chk("b2b_1_const", v, 64'b1011_0100110100_00);
    a_data = 8'hA5;
    chk("b2b_valid_held", a_valid, 1'b1);
    idle_check(0, "b2b_gap");
    frame_test(0, 8'hA5, 1'b0, "b2b_2", v);
    idle_check(0, "b2b_idle");

    // Reset during payload bit 3.
    a_data = 8'hFF; a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_pre_valid", a_bv, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid", {a_bv, a_busy, a_ready, a_done, a_bit}, 5'b00100);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold", {a_bv, a_busy, a_ready, a_done, a_bit}, 5'b00100);
    end
    reset = 1'b0;
    idle_check(0, "rst_release");
    frame_test(0, 8'h96, 1'b0, "after_rst", v);
    idle_check(0, "after_rst_idle");

    for (int i = 0; i < 20; i++) begin
      w = 8'($urandom);
      frame_test(0, w, 1'b0, "rand_a", v);
      idle_check(0, "rand_a_idle");
    end

    stream.delete();
    for (int i = 0; i < 200; i++) begin
      w = 8'($urandom);
      frame_test(1, w, 1'b0, "rand_b", v);
      idle_check(1, "rand_b_idle");
    end
    pulses = 0;
    for (int i = 0; i + 4 <= stream.size(); i++)
      if (stream[i] == 1'b1 && stream[i+1] == 1'b0 && stream[i+2] == 1'b1 && stream[i+3] == 1'b1)
        pulses++;
    chk("detector_pulses", pulses, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
